// File: rtl/axi_lite_regs.sv
// ---------------------------------------------------------------------------
// axi_lite_regs
//
// AXI4-Lite responder exposing NUM_REGS memory-mapped registers. Register
// contents are exported flat on reg_q_o for hardware consumers.
//
// Handshake rule: a beat transfers on any rising clk_i edge where its
// valid and ready are both high; a valid once raised is held with its
// payload until that edge, and the responder holds b_*/r_* stable while
// b_valid_o/r_valid_o wait for ready.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   aw_* / w_* / b_*         write address, write data, write response
//   ar_* / r_*               read address, read data/response
//   reg_q_o                  register i at [i*DATA_WIDTH +: DATA_WIDTH]
//
// Build option:
//   AXI_LITE_REGS_DECERR_EN  out-of-range accesses answer DECERR (2'b11)
//                            instead of SLVERR (2'b10); register side
//                            effects are identical either way.
//
// Internal FSM state is visible as w_state / r_state for checkers.
// ---------------------------------------------------------------------------
module axi_lite_regs #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_REGS   = 8,
    parameter logic [DATA_WIDTH-1:0] RST_VAL    = '0
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [ADDR_WIDTH-1:0]          aw_addr_i,
    input  logic                           aw_valid_i,
    output logic                           aw_ready_o,
    input  logic [DATA_WIDTH-1:0]          w_data_i,
    input  logic [DATA_WIDTH/8-1:0]        w_strb_i,
    input  logic                           w_valid_i,
    output logic                           w_ready_o,
    output logic [1:0]                     b_resp_o,
    output logic                           b_valid_o,
    input  logic                           b_ready_i,
    input  logic [ADDR_WIDTH-1:0]          ar_addr_i,
    input  logic                           ar_valid_i,
    output logic                           ar_ready_o,
    output logic [DATA_WIDTH-1:0]          r_data_o,
    output logic [1:0]                     r_resp_o,
    output logic                           r_valid_o,
    input  logic                           r_ready_i,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q_o
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int OFFS       = $clog2(STRB_WIDTH);
    localparam int IDXW       = ADDR_WIDTH - OFFS;
    // One extra bit so NUM_REGS itself is representable for the range test.
    localparam logic [IDXW:0] NUM_REGS_W = (IDXW+1)'(NUM_REGS);
    localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXI_LITE_REGS_DECERR_EN
    localparam logic [1:0] RESP_ERR  = 2'b11;
`else
    localparam logic [1:0] RESP_ERR  = 2'b10;
`endif

    typedef enum logic { W_IDLE, W_RESP } w_state_t;
    typedef enum logic { R_IDLE, R_RESP } r_state_t;

    w_state_t w_state, w_state_next;
    r_state_t r_state, r_state_next;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    // Write-side capture registers: AW and W may arrive in either order.
    logic                  aw_held, w_held;
    logic [IDXW-1:0]       aw_idx_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [STRB_WIDTH-1:0] w_strb_q;
    logic [1:0]            b_resp_q;

    logic [DATA_WIDTH-1:0] r_data_q;
    logic [1:0]            r_resp_q;

    logic                  aw_hs, w_hs, do_write, ar_hs;
    logic [IDXW-1:0]       wr_idx, rd_idx;
    logic [DATA_WIDTH-1:0] wr_data, rd_data;
    logic [STRB_WIDTH-1:0] wr_strb;
    logic                  wr_in_range, rd_in_range;

    // Byte-offset address bits carry no information for word registers.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{aw_addr_i[OFFS-1:0], ar_addr_i[OFFS-1:0]};

    // ---------------- write path ----------------
    // Handshakes are derived from state directly (not from the ready
    // outputs) to keep the FSM comb block free of feedback.
    assign aw_hs    = aw_valid_i && (w_state == W_IDLE) && !aw_held;
    assign w_hs     = w_valid_i  && (w_state == W_IDLE) && !w_held;
    assign do_write = (w_state == W_IDLE) && (aw_held || aw_hs) && (w_held || w_hs);

    always_comb begin
        wr_idx      = aw_held ? aw_idx_q : aw_addr_i[ADDR_WIDTH-1:OFFS];
        wr_data     = w_held  ? w_data_q : w_data_i;
        wr_strb     = w_held  ? w_strb_q : w_strb_i;
        wr_in_range = ({1'b0, wr_idx} < NUM_REGS_W);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w_state <= W_IDLE;
        end else begin
            w_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = w_state;
        aw_ready_o   = 1'b0;
        w_ready_o    = 1'b0;
        b_valid_o    = 1'b0;
        case (w_state)
            W_IDLE: begin
                aw_ready_o = !aw_held;
                w_ready_o  = !w_held;
                if (do_write) w_state_next = W_RESP;
            end
            W_RESP: begin
                b_valid_o = 1'b1;
                if (b_ready_i) w_state_next = W_IDLE;
            end
            default: w_state_next = W_IDLE;
        endcase
    end

    assign b_resp_o = b_resp_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            aw_idx_q <= '0;
            w_data_q <= '0;
            w_strb_q <= '0;
            b_resp_q <= RESP_OKAY;
        end else begin
            if (do_write) begin
                aw_held  <= 1'b0;
                w_held   <= 1'b0;
                b_resp_q <= wr_in_range ? RESP_OKAY : RESP_ERR;
            end else begin
                if (aw_hs) begin
                    aw_held  <= 1'b1;
                    aw_idx_q <= aw_addr_i[ADDR_WIDTH-1:OFFS];
                end
                if (w_hs) begin
                    w_held   <= 1'b1;
                    w_data_q <= w_data_i;
                    w_strb_q <= w_strb_i;
                end
            end
        end
    end

    // Register bank: an out-of-range index matches no entry, so it never
    // modifies anything.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= RST_VAL;
        end else if (do_write) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_idx == IDXW'(i)) begin
                    for (int b = 0; b < STRB_WIDTH; b++) begin
                        if (wr_strb[b]) regs[i][b*8 +: 8] <= wr_data[b*8 +: 8];
                    end
                end
            end
        end
    end

    // ---------------- read path ----------------
    assign ar_hs  = ar_valid_i && (r_state == R_IDLE);
    assign rd_idx = ar_addr_i[ADDR_WIDTH-1:OFFS];

    // Reads sample the bank before any same-edge write lands.
    always_comb begin
        rd_data     = '0;
        rd_in_range = ({1'b0, rd_idx} < NUM_REGS_W);
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_idx == IDXW'(i)) rd_data = regs[i];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= r_state_next;
        end
    end

    always_comb begin
        r_state_next = r_state;
        ar_ready_o   = 1'b0;
        r_valid_o    = 1'b0;
        case (r_state)
            R_IDLE: begin
                ar_ready_o = 1'b1;
                if (ar_hs) r_state_next = R_RESP;
            end
            R_RESP: begin
                r_valid_o = 1'b1;
                if (r_ready_i) r_state_next = R_IDLE;
            end
            default: r_state_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_data_q <= '0;
            r_resp_q <= RESP_OKAY;
        end else if (ar_hs) begin
            r_data_q <= rd_data;
            r_resp_q <= rd_in_range ? RESP_OKAY : RESP_ERR;
        end
    end

    assign r_data_o = r_data_q;
    assign r_resp_o = r_resp_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign reg_q_o[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
    end

endmodule
